// File: rtl/uart_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sequencer
// Description : Byte FIFO that feeds the single-byte UART_TX engine and owns
//               its start_TX / SBUF_in handshake. Define UART_TX_SEQ_INT_EN
//               to build the tx_empty_int pulse and same-edge push bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sequencer #(
    parameter int FIFO_DEPTH     = 16,
    parameter int FIFO_ADDR_BITS = 4,
    parameter int GUARD_CYCLES   = 0,
    parameter int ACK_TIMEOUT    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sync_reset,
    input  logic                    wr_en,
    input  logic [7:0]              wr_data,
    output logic                    fifo_full,
    output logic [FIFO_ADDR_BITS:0] fifo_count,
    output logic                    busy,
    output logic                    overflow,
    output logic                    ack_err,
    output logic                    start_TX,
    output logic [7:0]              tx_data,
    input  logic                    tx_active,
    output logic                    tx_empty_int
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_LAUNCH   = 3'd1;
    localparam logic [2:0] c_ACK_WAIT = 3'd2;
    localparam logic [2:0] c_BUSY     = 3'd3;
    localparam logic [2:0] c_GAP      = 3'd4;

    localparam int                    c_ACK_W    = $clog2(ACK_TIMEOUT);
    localparam logic [c_ACK_W-1:0]    c_ACK_LAST = c_ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [7:0]            c_GUARD    = 8'(GUARD_CYCLES);
    localparam logic [FIFO_ADDR_BITS:0] c_FULL   = (FIFO_ADDR_BITS + 1)'(FIFO_DEPTH);

    logic [7:0]                r_mem [FIFO_DEPTH];
    logic [FIFO_ADDR_BITS-1:0] r_wr_ptr;
    logic [FIFO_ADDR_BITS-1:0] r_rd_ptr;
    logic [FIFO_ADDR_BITS:0]   r_count;
    logic [2:0]                r_state;
    logic [7:0]                r_gap_cnt;
    logic [c_ACK_W-1:0]        r_ack_cnt;
    logic                      r_full;
    logic                      r_busy;
    logic                      r_overflow;
    logic                      r_ack_err;
    logic                      r_start_tx;
    logic [7:0]                r_tx_data;

    logic [2:0]                w_next_state;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_drop;
    logic                      w_bypass;
    logic                      w_ack_timeout;
    logic [FIFO_ADDR_BITS:0]   w_next_count;
`ifdef UART_TX_SEQ_INT_EN
    logic                      w_int_pulse;
    logic                      r_tx_empty_int;
`endif

    always_comb begin
        w_next_state  = r_state;
        w_pop         = 1'b0;
        w_bypass      = 1'b0;
        w_ack_timeout = 1'b0;
`ifdef UART_TX_SEQ_INT_EN
        w_int_pulse   = 1'b0;
`endif
        case (r_state)
            c_IDLE: begin
                if (r_count != '0) begin
                    w_next_state = c_LAUNCH;
                    w_pop        = 1'b1;
                end
            end
            c_LAUNCH: w_next_state = c_ACK_WAIT;
            c_ACK_WAIT: begin
                if (tx_active) begin
                    w_next_state = c_BUSY;
                end else if (r_ack_cnt == c_ACK_LAST) begin
                    w_next_state  = c_GAP;
                    w_ack_timeout = 1'b1;
                end
            end
            c_BUSY: begin
                if (!tx_active) w_next_state = c_GAP;
            end
            c_GAP: begin
                if (r_gap_cnt == 8'd0) begin
                    if (r_count != '0) begin
                        w_next_state = c_LAUNCH;
                        w_pop        = 1'b1;
`ifdef UART_TX_SEQ_INT_EN
                    // A byte arriving on the drain edge goes straight to UART_TX
                    end else if (wr_en) begin
                        w_next_state = c_LAUNCH;
                        w_bypass     = 1'b1;
                    end else begin
                        w_next_state = c_IDLE;
                        w_int_pulse  = 1'b1;
`else
                    end else begin
                        w_next_state = c_IDLE;
`endif
                    end
                end
            end
            default: w_next_state = c_IDLE;
        endcase

        // A pop on the same edge frees a slot, so a push into a full FIFO still lands
        w_push = wr_en & ~w_bypass & ((r_count != c_FULL) | w_pop);
        w_drop = wr_en & ~w_bypass & (r_count == c_FULL) & ~w_pop;

        w_next_count = r_count;
        if (w_push && !w_pop) begin
            w_next_count = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_next_count = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_gap_cnt  <= 8'd0;
            r_ack_cnt  <= '0;
            r_full     <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
            r_ack_err  <= 1'b0;
            r_start_tx <= 1'b0;
            r_tx_data  <= 8'd0;
        end else if (sync_reset) begin
            r_state    <= c_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_gap_cnt  <= 8'd0;
            r_ack_cnt  <= '0;
            r_full     <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
            r_ack_err  <= 1'b0;
            r_start_tx <= 1'b0;
            r_tx_data  <= 8'd0;
        end else begin
            r_state    <= w_next_state;
            r_count    <= w_next_count;
            r_full     <= (w_next_count == c_FULL);
            r_busy     <= (w_next_state != c_IDLE) | (w_next_count != '0);
            r_overflow <= r_overflow | w_drop;
            r_ack_err  <= r_ack_err | w_ack_timeout;
            r_start_tx <= (w_next_state == c_LAUNCH);

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_tx_data <= r_mem[r_rd_ptr];
            end else if (w_bypass) begin
                r_tx_data <= wr_data;
            end

            if (r_state != c_GAP && w_next_state == c_GAP) begin
                r_gap_cnt <= c_GUARD;
            end else if (r_state == c_GAP && r_gap_cnt != 8'd0) begin
                r_gap_cnt <= r_gap_cnt - 8'd1;
            end

            if (r_state != c_ACK_WAIT) begin
                r_ack_cnt <= '0;
            end else begin
                r_ack_cnt <= r_ack_cnt + 1'b1;
            end
        end
    end

`ifdef UART_TX_SEQ_INT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_empty_int <= 1'b0;
        end else if (sync_reset) begin
            r_tx_empty_int <= 1'b0;
        end else begin
            r_tx_empty_int <= w_int_pulse;
        end
    end
    assign tx_empty_int = r_tx_empty_int;
`else
    assign tx_empty_int = 1'b0;
`endif

    assign fifo_full  = r_full;
    assign fifo_count = r_count;
    assign busy       = r_busy;
    assign overflow   = r_overflow;
    assign ack_err    = r_ack_err;
    assign start_TX   = r_start_tx;
    assign tx_data    = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_sequencer
// Description : Scoreboard bench for uart_tx_sequencer with a simple UART_TX
//               responder; interrupt checks follow UART_TX_SEQ_INT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sequencer;

    localparam int TB_GUARD = 3;
    localparam int TB_ACK   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sync_reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       tx_active = 1'b0;
    logic       fifo_full;
    logic [4:0] fifo_count;
    logic       busy;
    logic       overflow;
    logic       ack_err;
    logic       start_TX;
    logic [7:0] tx_data;
    logic       tx_empty_int;

    uart_tx_sequencer #(
        .FIFO_DEPTH     (16),
        .FIFO_ADDR_BITS (4),
        .GUARD_CYCLES   (TB_GUARD),
        .ACK_TIMEOUT    (TB_ACK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sync_reset   (sync_reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .busy         (busy),
        .overflow     (overflow),
        .ack_err      (ack_err),
        .start_TX     (start_TX),
        .tx_data      (tx_data),
        .tx_active    (tx_active),
        .tx_empty_int (tx_empty_int)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miscomp = 0;
    int cyc = 0;
    logic [7:0] sb [$];

    // UART responder controls and observations
    int active_len = 20;
    bit uart_stall = 1'b0;
    bit uart_dead = 1'b0;
    int m_held = 0;
    int fall_edge = -1;

    // Monitor state
    bit chk_spacing = 1'b0;
    int last_fall = -1;
    int n_start = 0;
    int n_full_rise = 0;
    bit prev_full = 1'b0;
    int n_int = 0;
    int int_at_start = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscomp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) sb.push_back(d);
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy && i < budget) begin
            step(1);
            i++;
        end
        check_eq("idle_reached", 32'(busy), 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // tx_active rises the edge after start_TX is seen and falls after active_len cycles
    always begin
        @(negedge clk);
        if (start_TX && !reset && !uart_dead) begin
            @(posedge clk);
            #1 tx_active = 1'b1;
            m_held = 1;
            while (m_held < active_len || uart_stall) begin
                @(posedge clk);
                m_held++;
            end
            #1 tx_active = 1'b0;
            // first edge at which the sequencer samples the line low
            fall_edge = cyc + 1;
        end
    end

    always begin
        @(negedge clk);
        if (!reset) begin
            if (start_TX) begin
                n_start++;
                check_eq("no_overlap", 32'(tx_active), 0);
                check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) check_eq("tx_data", 32'(tx_data), 32'(sb.pop_front()));
                if (chk_spacing && fall_edge != last_fall)
                    check_eq("spacing", cyc - fall_edge, TB_GUARD + 1);
                last_fall = fall_edge;
            end
            if (fifo_full && !prev_full) n_full_rise++;
            prev_full = fifo_full;
            if (tx_empty_int) begin
                n_int++;
                int_at_start = n_start;
`ifdef UART_TX_SEQ_INT_EN
                check_eq("int_when_idle", 32'(busy), 0);
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int base;
        int int_base;

        // ---- reset state
        step(2);
        check_eq("rst_count", 32'(fifo_count), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_start", 32'(start_TX), 0);
        check_eq("rst_full", 32'(fifo_full), 0);
        check_eq("rst_flags", {30'd0, overflow, ack_err}, 0);
        check_eq("rst_int", 32'(tx_empty_int), 0);
        reset = 1'b0;
        step(2);

        // ---- 1: single byte latency and busy release
        active_len = 100;
        push(8'h55, 1'b1);
        check_eq("t1_start_n", 32'(start_TX), 0);
        check_eq("t1_count", 32'(fifo_count), 1);
        check_eq("t1_busy", 32'(busy), 1);
        step(1);
        check_eq("t1_start_n1", 32'(start_TX), 1);
        check_eq("t1_count_pop", 32'(fifo_count), 0);
        step(1);
        check_eq("t1_start_n2", 32'(start_TX), 0);
        step(1);
        check_eq("t1_active", 32'(tx_active), 1);
        i = 0;
        while (tx_active && i < 300) begin step(1); i++; end
        check_eq("t1_fall", 32'(tx_active), 0);
        i = 0;
        while (busy && i < 50) begin step(1); i++; end
        check_eq("t1_busy_fall", i, TB_GUARD + 2);
        check_eq("t1_data_held", 32'(tx_data), 32'h55);

        // ---- 2: 16 bytes queued behind an in-flight byte
        active_len  = 20;
        base        = n_start;
        n_full_rise = 0;
        push(8'hA0, 1'b1);
        for (int k = 1; k <= 16; k++) push(8'(k), 1'b1);
        check_eq("t2_full", 32'(fifo_full), 1);
        chk_spacing = 1'b1;
        wait_idle(3000);
        chk_spacing = 1'b0;
        check_eq("t2_pulses", n_start - base, 17);
        check_eq("t2_sb_drained", 32'(sb.size()), 0);
        check_eq("t2_full_once", n_full_rise, 1);
        check_eq("t2_overflow", 32'(overflow), 0);

        // ---- 3: overflow while stalled, then sync flush
        active_len = 4;
        uart_stall = 1'b1;
        push(8'hB0, 1'b1);
        step(2);
        for (int k = 0; k < 17; k++) push(8'(8'h30 + k), k < 16);
        check_eq("t3_overflow", 32'(overflow), 1);
        check_eq("t3_count", 32'(fifo_count), 16);
        check_eq("t3_full", 32'(fifo_full), 1);
        sync_reset = 1'b1;
        step(1);
        sync_reset = 1'b0;
        sb.delete();
        check_eq("t3_flush_count", 32'(fifo_count), 0);
        check_eq("t3_flush_ovf", 32'(overflow), 0);
        check_eq("t3_flush_full", 32'(fifo_full), 0);
        check_eq("t3_flush_busy", 32'(busy), 0);
        base       = n_start;
        uart_stall = 1'b0;
        step(30);
        check_eq("t3_no_start", n_start - base, 0);

        // ---- 4: push lands on the launch pop of a full FIFO
        uart_stall = 1'b1;
        push(8'hC0, 1'b1);
        step(2);
        for (int k = 0; k < 16; k++) push(8'(8'h40 + k), 1'b1);
        check_eq("t4_count_full", 32'(fifo_count), 16);
        uart_stall = 1'b0;
        step(1);
        check_eq("t4_fall", 32'(tx_active), 0);
        step(TB_GUARD + 1);
        push(8'hEE, 1'b1);
        check_eq("t4_launch", 32'(start_TX), 1);
        check_eq("t4_count", 32'(fifo_count), 16);
        check_eq("t4_full", 32'(fifo_full), 1);
        check_eq("t4_overflow", 32'(overflow), 0);
        wait_idle(3000);
        check_eq("t4_sb_drained", 32'(sb.size()), 0);

        // ---- 5: UART never acknowledges
        uart_dead = 1'b1;
        push(8'hD1, 1'b1);
        step(1);
        check_eq("t5_launch", 32'(start_TX), 1);
        step(TB_ACK);
        check_eq("t5_ackerr_early", 32'(ack_err), 0);
        step(1);
        check_eq("t5_ackerr", 32'(ack_err), 1);
        uart_dead = 1'b0;
        push(8'hD2, 1'b1);
        wait_idle(500);
        check_eq("t5_sb_drained", 32'(sb.size()), 0);
        check_eq("t5_ackerr_sticky", 32'(ack_err), 1);

        // ---- 6: interrupt after the last byte, then async reset mid-transfer
        int_base = n_int;
        base     = n_start;
        push(8'hE1, 1'b1);
        push(8'hE2, 1'b1);
        wait_idle(500);
`ifdef UART_TX_SEQ_INT_EN
        check_eq("t6_int_count", n_int - int_base, 1);
        check_eq("t6_int_after_b2", int_at_start - base, 2);
`else
        check_eq("t6_int_tied_low", n_int, 0);
`endif
        push(8'hF1, 1'b1);
        step(5);
        check_eq("t6_busy_mid", 32'(busy), 1);
        #1 reset = 1'b1;
        #1;
        sb.delete();
        check_eq("t6_rst_start", 32'(start_TX), 0);
        check_eq("t6_rst_data", 32'(tx_data), 0);
        check_eq("t6_rst_busy", 32'(busy), 0);
        check_eq("t6_rst_count", 32'(fifo_count), 0);
        check_eq("t6_rst_flags", {29'd0, fifo_full, overflow, ack_err}, 0);
        check_eq("t6_rst_int", 32'(tx_empty_int), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
        $finish;
    end

endmodule
`default_nettype wire
